// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter and its round-robin picker.
package tcdm_arb_pkg;

    localparam int unsigned MaxReq       = 32;
    localparam int unsigned MaxIdxW      = $clog2(MaxReq);
    localparam int unsigned NumReqDef    = 4;
    localparam int unsigned DataWidthDef = 32;
    localparam int unsigned BeWidth      = DataWidthDef / 8;

    typedef logic [$clog2(NumReqDef)-1:0] idx_t;

    // Scans downward so the lowest offset from ptr overwrites last and wins.
    // With no request set the pointer itself is returned.
    function automatic int rr_pick(input logic [MaxReq-1:0] req,
                                   input int num_req,
                                   input int ptr);
        int idx;
        int win;
        win = ptr;
        for (int i = MaxReq - 1; i >= 0; i--) begin
            if (i < num_req) begin
                idx = ptr + i;
                if (idx >= num_req) idx = idx - num_req;
                if (req[idx[MaxIdxW-1:0]]) win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/tcdm_rr_picker.sv
// Combinational round-robin find-first-set starting at a pointer, with index output.
module tcdm_rr_picker
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NumReq = NumReqDef
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic [$clog2(NumReq)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [MaxReq-1:0] req_ext;
    int                pick;

    always_comb begin
        req_ext               = '0;
        req_ext[NumReq-1:0]   = req_i;
        pick                  = rr_pick(req_ext, int'(NumReq), int'(ptr_i));
        idx_o                 = IdxW'(pick);
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin sharing of one single-ported TCDM bank between NumReq requesters.
// Optional per-requester stall counters: TCDM_BANK_ARBITER_STALL_CNT_EN.
module tcdm_bank_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NumReq        = NumReqDef,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = DataWidthDef,
    parameter int unsigned IdWidth       = 1,
    parameter int unsigned StallCntWidth = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReq-1:0]                      req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]       add_i,
    input  logic [NumReq-1:0]                      wen_i,
    input  logic [NumReq-1:0][DataWidth-1:0]       data_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
    input  logic [NumReq-1:0][IdWidth-1:0]         id_i,
    output logic [NumReq-1:0]                      gnt_o,
    output logic [NumReq-1:0]                      r_valid_o,
    output logic [DataWidth-1:0]                   r_data_o,
    output logic [IdWidth-1:0]                     r_id_o,
    output logic                                   bank_req_o,
    output logic [AddrWidth-1:0]                   bank_add_o,
    output logic                                   bank_wen_o,
    output logic [DataWidth-1:0]                   bank_data_o,
    output logic [DataWidth/8-1:0]                 bank_be_o,
    output logic [IdWidth-1:0]                     bank_id_o,
    input  logic                                   bank_gnt_i,
    input  logic                                   bank_r_valid_i,
    input  logic [DataWidth-1:0]                   bank_r_data_i,
    input  logic [IdWidth-1:0]                     bank_r_id_i,
    input  logic                                   stall_clr_i,
    output logic [NumReq-1:0][StallCntWidth-1:0]   stall_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] rr_q, rr_next, win_idx, resp_idx_q;
    logic            resp_pend_q;
    logic            hs;

    tcdm_rr_picker #(
        .NumReq (NumReq)
    ) i_picker (
        .req_i   (req_i),
        .ptr_i   (rr_q),
        .idx_o   (win_idx),
        .valid_o (bank_req_o)
    );

    // With no request the picker returns rr_q, so the idle payload comes from rr_q.
    assign bank_add_o  = add_i[win_idx];
    assign bank_wen_o  = wen_i[win_idx];
    assign bank_data_o = data_i[win_idx];
    assign bank_be_o   = be_i[win_idx];
    assign bank_id_o   = id_i[win_idx];

    assign hs = bank_req_o & bank_gnt_i;

    always_comb begin
        gnt_o          = '0;
        gnt_o[win_idx] = hs;
    end

    assign rr_next = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            resp_pend_q <= 1'b0;
            resp_idx_q  <= '0;
        end else begin
            resp_pend_q <= hs & bank_wen_o;
            if (hs) begin
                rr_q       <= rr_next;
                resp_idx_q <= win_idx;
            end
        end
    end

    always_comb begin
        r_valid_o             = '0;
        r_valid_o[resp_idx_q] = bank_r_valid_i & resp_pend_q;
    end

    assign r_data_o = bank_r_data_i;
    assign r_id_o   = bank_r_id_i;

`ifdef TCDM_BANK_ARBITER_STALL_CNT_EN
    logic [NumReq-1:0][StallCntWidth-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_clr_i) begin
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (req_i[k] && !gnt_o[k] && !(&stall_cnt_q[k])) begin
                    stall_cnt_q[k] <= stall_cnt_q[k] + StallCntWidth'(1);
                end
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr_i;
    assign stall_cnt_o      = '0;
`endif

`ifndef SYNTHESIS
    // The bank answers every read exactly one cycle after its handshake, never writes.
    resp_track_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bank_r_valid_i == resp_pend_q);
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed self-checking bench for tcdm_bank_arbiter with a 1-cycle-latency bank model.
module tb_tcdm_bank_arbiter;

    localparam int unsigned NumReq        = 4;
    localparam int unsigned AddrWidth     = 32;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned IdWidth       = 1;
    localparam int unsigned StallCntWidth = 4;
    localparam int unsigned BeW           = DataWidth / 8;

`ifdef TCDM_BANK_ARBITER_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic                                  clk_i = 1'b0;
    logic                                  rst_ni;
    logic [NumReq-1:0]                     req_i;
    logic [NumReq-1:0][AddrWidth-1:0]      add_i;
    logic [NumReq-1:0]                     wen_i;
    logic [NumReq-1:0][DataWidth-1:0]      data_i;
    logic [NumReq-1:0][BeW-1:0]            be_i;
    logic [NumReq-1:0][IdWidth-1:0]        id_i;
    logic [NumReq-1:0]                     gnt_o;
    logic [NumReq-1:0]                     r_valid_o;
    logic [DataWidth-1:0]                  r_data_o;
    logic [IdWidth-1:0]                    r_id_o;
    logic                                  bank_req_o;
    logic [AddrWidth-1:0]                  bank_add_o;
    logic                                  bank_wen_o;
    logic [DataWidth-1:0]                  bank_data_o;
    logic [BeW-1:0]                        bank_be_o;
    logic [IdWidth-1:0]                    bank_id_o;
    logic                                  bank_gnt_i;
    logic                                  bank_r_valid_i = 1'b0;
    logic [DataWidth-1:0]                  bank_r_data_i = '0;
    logic [IdWidth-1:0]                    bank_r_id_i = '0;
    logic                                  stall_clr_i;
    logic [NumReq-1:0][StallCntWidth-1:0]  stall_cnt_o;

    int n_vec;
    int n_err;

    always #5 clk_i = ~clk_i;

    tcdm_bank_arbiter #(
        .NumReq        (NumReq),
        .AddrWidth     (AddrWidth),
        .DataWidth     (DataWidth),
        .IdWidth       (IdWidth),
        .StallCntWidth (StallCntWidth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .add_i          (add_i),
        .wen_i          (wen_i),
        .data_i         (data_i),
        .be_i           (be_i),
        .id_i           (id_i),
        .gnt_o          (gnt_o),
        .r_valid_o      (r_valid_o),
        .r_data_o       (r_data_o),
        .r_id_o         (r_id_o),
        .bank_req_o     (bank_req_o),
        .bank_add_o     (bank_add_o),
        .bank_wen_o     (bank_wen_o),
        .bank_data_o    (bank_data_o),
        .bank_be_o      (bank_be_o),
        .bank_id_o      (bank_id_o),
        .bank_gnt_i     (bank_gnt_i),
        .bank_r_valid_i (bank_r_valid_i),
        .bank_r_data_i  (bank_r_data_i),
        .bank_r_id_i    (bank_r_id_i),
        .stall_clr_i    (stall_clr_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Bank model: read data is the address xor a tag, returned one cycle later.
    always_ff @(posedge clk_i) begin
        bank_r_valid_i <= bank_req_o & bank_gnt_i & bank_wen_o;
        bank_r_data_i  <= bank_add_o ^ 32'hDEAD_0000;
        bank_r_id_i    <= bank_id_o;
    end

    function automatic logic [31:0] exp_add(input int k);
        return 32'h10 + 32'h100 * k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int              ord [8];
        logic [3:0]      exp_rv;
        logic [31:0]     exp_rd;
        logic [3:0]      e3, e15;

        ord    = '{1, 2, 3, 0, 1, 2, 3, 0};
        e3     = CntEn ? 4'd3 : 4'd0;
        e15    = CntEn ? 4'd15 : 4'd0;
        n_vec  = 0;
        n_err  = 0;
        rst_ni      = 1'b0;
        req_i       = '0;
        bank_gnt_i  = 1'b0;
        stall_clr_i = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            add_i[k]  = exp_add(k);
            wen_i[k]  = 1'b1;
            data_i[k] = 32'hC0DE_0000 + 32'(k);
            be_i[k]   = BeW'(1 << k);
            id_i[k]   = IdWidth'(k % 2);
        end

        // reset state and combinational grant during reset
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_gnt_idle", 64'(gnt_o), 0);
        check("rst_breq_idle", 64'(bank_req_o), 0);
        check("rst_rvalid", 64'(r_valid_o), 0);
        check("rst_stall", 64'(stall_cnt_o), 0);
        req_i = 4'b0001; bank_gnt_i = 1'b1; #1;
        check("rst_gnt_comb", 64'(gnt_o), 64'b0001);
        req_i = '0; #1;
        rst_ni = 1'b1;

        // single read from requester 0
        @(posedge clk_i); #1;
        req_i = 4'b0001; #1;
        check("t1_gnt", 64'(gnt_o), 64'b0001);
        check("t1_badd", 64'(bank_add_o), 64'h10);
        check("t1_bwen", 64'(bank_wen_o), 1);
        @(posedge clk_i); #1;
        req_i = '0; #1;
        check("t1_rvalid", 64'(r_valid_o), 64'b0001);
        check("t1_rdata", 64'(r_data_o), 64'hDEAD_0010);
        check("t1_gnt_idle", 64'(gnt_o), 0);

        // all four reading, pointer starts at 1
        exp_rv = '0;
        exp_rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            req_i = 4'b1111; #1;
            check("t2_gnt", 64'(gnt_o), 64'(1 << ord[i]));
            check("t2_badd", 64'(bank_add_o), 64'(exp_add(ord[i])));
            check("t2_rvalid", 64'(r_valid_o), 64'(exp_rv));
            if (exp_rv != 0) check("t2_rdata", 64'(r_data_o), 64'(exp_rd));
            exp_rv = 4'(1 << ord[i]);
            exp_rd = exp_add(ord[i]) ^ 32'hDEAD_0000;
        end
        @(posedge clk_i); #1;
        req_i = '0; #1;
        check("t2_rvalid_last", 64'(r_valid_o), 64'b0001);
        check("t2_rdata_last", 64'(r_data_o), 64'hDEAD_0010);

        // two requesters writing, pointer at 1
        @(posedge clk_i); #1;
        wen_i = '0; req_i = 4'b0101; #1;
        check("t3_gnt_a", 64'(gnt_o), 64'b0100);
        check("t3_bwen", 64'(bank_wen_o), 0);
        check("t3_bdata", 64'(bank_data_o), 64'hC0DE_0002);
        check("t3_bbe", 64'(bank_be_o), 64'b0100);
        @(posedge clk_i); #1; #1;
        check("t3_gnt_b", 64'(gnt_o), 64'b0001);
        check("t3_bdata_b", 64'(bank_data_o), 64'hC0DE_0000);
        check("t3_rvalid_b", 64'(r_valid_o), 0);
        @(posedge clk_i); #1; #1;
        check("t3_gnt_c", 64'(gnt_o), 64'b0100);
        check("t3_rvalid_c", 64'(r_valid_o), 0);
        @(posedge clk_i); #1;
        req_i = '0; wen_i = '1; stall_clr_i = 1'b1; #1;
        check("t3_rvalid_d", 64'(r_valid_o), 0);
        check("t3_breq_idle", 64'(bank_req_o), 0);
        check("t3_idle_add", 64'(bank_add_o), 64'h310);

        // bank stalls three cycles with requesters 0 and 1 pending
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            stall_clr_i = 1'b0; req_i = 4'b0011; bank_gnt_i = 1'b0; #1;
            check("t4_gnt_stall", 64'(gnt_o), 0);
            check("t4_breq", 64'(bank_req_o), 1);
            check("t4_badd", 64'(bank_add_o), 64'h10);
        end
        @(posedge clk_i); #1;
        check("t4_stall0", 64'(stall_cnt_o[0]), 64'(e3));
        check("t4_stall1", 64'(stall_cnt_o[1]), 64'(e3));
        check("t4_stall2", 64'(stall_cnt_o[2]), 0);
        req_i = 4'b1111; bank_gnt_i = 1'b1; stall_clr_i = 1'b1; #1;
        check("t4_gnt_ptr3", 64'(gnt_o), 64'b1000);

        // reset the cycle after a read grant drops the response
        @(posedge clk_i); #1;
        stall_clr_i = 1'b0;
        check("t4_stall_clr", 64'(stall_cnt_o), 0);
        req_i = '0; rst_ni = 1'b0; #1;
        check("t5_rvalid_drop", 64'(r_valid_o), 0);
        check("t5_gnt_rst", 64'(gnt_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; req_i = 4'b1000; #1;
        check("t5_gnt_single", 64'(gnt_o), 64'b1000);
        @(posedge clk_i); #1;
        req_i = '0; #1;
        check("t5_rvalid", 64'(r_valid_o), 64'b1000);
        check("t5_rdata", 64'(r_data_o), 64'hDEAD_0310);
        check("t5_rid", 64'(r_id_o), 1);

        // long stall saturates the 4-bit counters
        @(posedge clk_i); #1;
        req_i = 4'b0011; bank_gnt_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        check("t6_sat0", 64'(stall_cnt_o[0]), 64'(e15));
        check("t6_sat1", 64'(stall_cnt_o[1]), 64'(e15));
        check("t6_idle3", 64'(stall_cnt_o[3]), 0);
        req_i = '0; stall_clr_i = 1'b1;
        @(posedge clk_i); #1;
        stall_clr_i = 1'b0;
        check("t6_clr", 64'(stall_cnt_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
